// File: rtl/exec_unit.sv
// Execute stage: single-cycle ALU plus a DWIDTH-cycle shift-add multiplier,
// returning write-back data with a one-hot register write enable.
module exec_unit #(
    parameter int DWIDTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_in,
    input  logic [2:0]        op,
    input  logic [1:0]        dst,
    input  logic [DWIDTH-1:0] a_in,
    input  logic [DWIDTH-1:0] b_in,
    output logic [DWIDTH-1:0] result,
    output logic [3:0]        reg_en,
    output logic              en_out,
    output logic              busy,
    output logic              flag_z,
    output logic              flag_c
);
    localparam int CW = $clog2(DWIDTH + 1);

    typedef enum logic [2:0] {
        OP_MOV = 3'b000, OP_ADD = 3'b001, OP_SUB = 3'b010, OP_AND = 3'b011,
        OP_OR  = 3'b100, OP_XOR = 3'b101, OP_SHL = 3'b110, OP_MUL = 3'b111
    } op_t;

    typedef enum logic {IDLE, MUL} state_t;

    state_t              state, state_nxt;
    logic [DWIDTH-1:0]   result_nxt, mplier, mplier_nxt, alu_res;
    logic [2*DWIDTH-1:0] mcand, mcand_nxt, acc, acc_nxt, acc_sum;
    logic [CW-1:0]       cnt, cnt_nxt;
    logic [1:0]          dst_q, dst_q_nxt;
    logic [3:0]          reg_en_nxt;
    logic                en_out_nxt, busy_nxt, flag_z_nxt, flag_c_nxt, alu_c;
    logic [DWIDTH:0]     wide;

    // Single-cycle ALU; bit DWIDTH of the widened add/subtract is carry or borrow.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        alu_res = '0;
        alu_c   = 1'b0;
        wide    = '0;
        unique case (op_t'(op))
            OP_MOV: alu_res = b_in;
            OP_ADD: begin
                wide    = {1'b0, a_in} + {1'b0, b_in};
                alu_res = wide[DWIDTH-1:0];
                alu_c   = wide[DWIDTH];
            end
            OP_SUB: begin
                wide    = {1'b0, a_in} - {1'b0, b_in};
                alu_res = wide[DWIDTH-1:0];
                alu_c   = wide[DWIDTH];
            end
            OP_AND: alu_res = a_in & b_in;
            OP_OR:  alu_res = a_in | b_in;
            OP_XOR: alu_res = a_in ^ b_in;
            OP_SHL: begin
                alu_res = {a_in[DWIDTH-2:0], 1'b0};
                alu_c   = a_in[DWIDTH-1];
            end
            OP_MUL: alu_res = '0;
        endcase
    end

    assign acc_sum = acc + (mplier[0] ? mcand : '0);

    always_comb begin
        state_nxt  = state;
        result_nxt = result;
        reg_en_nxt = '0;
        en_out_nxt = 1'b0;
        busy_nxt   = busy;
        flag_z_nxt = flag_z;
        flag_c_nxt = flag_c;
        mcand_nxt  = mcand;
        mplier_nxt = mplier;
        acc_nxt    = acc;
        cnt_nxt    = cnt;
        dst_q_nxt  = dst_q;
        unique case (state)
            IDLE: if (en_in) begin
                if (op_t'(op) == OP_MUL) begin
                    mcand_nxt  = {{DWIDTH{1'b0}}, a_in};
                    mplier_nxt = b_in;
                    acc_nxt    = '0;
                    cnt_nxt    = '0;
                    dst_q_nxt  = dst;
                    busy_nxt   = 1'b1;
                    state_nxt  = MUL;
                end else begin
                    result_nxt = alu_res;
                    reg_en_nxt = 4'b0001 << dst;
                    en_out_nxt = 1'b1;
                    flag_z_nxt = (alu_res == '0);
                    flag_c_nxt = alu_c;
                end
            end
            MUL: begin
                // en_in is deliberately ignored here; the issuer must watch busy.
                acc_nxt    = acc_sum;
                mcand_nxt  = mcand << 1;
                mplier_nxt = mplier >> 1;
                cnt_nxt    = cnt + CW'(1);
                if (cnt == CW'(DWIDTH - 1)) begin
                    result_nxt = acc_sum[DWIDTH-1:0];
                    reg_en_nxt = 4'b0001 << dst_q;
                    en_out_nxt = 1'b1;
                    flag_z_nxt = (acc_sum[DWIDTH-1:0] == '0);
                    flag_c_nxt = |acc_sum[2*DWIDTH-1:DWIDTH];
                    busy_nxt   = 1'b0;
                    state_nxt  = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            state  <= IDLE;
            result <= '0;
            reg_en <= '0;
            en_out <= 1'b0;
            busy   <= 1'b0;
            flag_z <= 1'b0;
            flag_c <= 1'b0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            dst_q  <= '0;
        end else begin
            state  <= state_nxt;
            result <= result_nxt;
            reg_en <= reg_en_nxt;
            en_out <= en_out_nxt;
            busy   <= busy_nxt;
            flag_z <= flag_z_nxt;
            flag_c <= flag_c_nxt;
            mcand  <= mcand_nxt;
            mplier <= mplier_nxt;
            acc    <= acc_nxt;
            cnt    <= cnt_nxt;
            dst_q  <= dst_q_nxt;
        end
    end
endmodule
